// File: rtl/ifu_fetch_unit.sv
// ifu_fetch_unit: instruction fetch stage feeding decode.
// Holds the architectural PC and issues one memory read per instruction.
// At most one fetch is in flight. The next fetch starts only after execute
// supplies the next PC (dnpc).
// Optional build macro IFU_TIMEOUT_EN adds a fetch watchdog. If the read
// address and data phases together run for TIMEOUT cycles, the unit goes to
// the error state with cause 3. In the default build the FSM waits forever.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | first cycle after reset; checks RESET_PC alignment
// ADDR   | imem_arvalid high, waiting for imem_arready
// DATA   | imem_rready high, waiting for imem_rvalid
// HOLD   | inst_valid high, waiting for decode to take the instruction
// WAIT   | instruction consumed, waiting for dnpc from execute
// ERR    | terminal error; only rst leaves this state

module ifu_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dnpc_valid,
   input  logic [31:0] dnpc,
   output logic        imem_arvalid,
   output logic [31:0] imem_araddr,
   input  logic        imem_arready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic [1:0]  imem_rresp,
   output logic        imem_rready,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        fetch_err,
   output logic [1:0]  err_cause,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_HOLD,
      S_WAIT,
      S_ERR
   } state_t;

   localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0] CAUSE_BUS      = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_fetch_cnt;
   logic        r_arvalid;
   logic        r_rready;
   logic        r_inst_valid;
   logic        r_fetch_err;
   logic [1:0]  r_err_cause;

   logic        w_dnpc_aligned;
   logic        w_timeout;

   assign w_dnpc_aligned = (dnpc[1:0] == 2'b00);

`ifdef IFU_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [TW-1:0] r_to_cnt;

   // Watchdog: zero outside a fetch, counts every cycle spent in ADDR or DATA.
   // ADDR is only ever entered from a non-fetch state, so the count restarts
   // at zero for each fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (r_state == S_ADDR || r_state == S_DATA) begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
         r_to_cnt <= '0;
      end
   end

   // The TIMEOUT-th edge in ADDR+DATA fires. The compare is >= because an
   // address handshake on that edge wins and carries the count into DATA.
   assign w_timeout = (r_to_cnt >= TW'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // Fetch FSM. Every output is a register updated together with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_inst       <= '0;
         r_fetch_cnt  <= '0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_inst_valid <= 1'b0;
         r_fetch_err  <= 1'b0;
         r_err_cause  <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_pc[1:0] == 2'b00) begin
                  r_state   <= S_ADDR;
                  r_arvalid <= 1'b1;
               end else begin
                  r_state     <= S_ERR;
                  r_fetch_err <= 1'b1;
                  r_err_cause <= CAUSE_MISALIGN;
               end
            end

            S_ADDR: begin
               if (imem_arready) begin
                  r_state   <= S_DATA;
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
               end else if (w_timeout) begin
                  r_state     <= S_ERR;
                  r_arvalid   <= 1'b0;
                  r_fetch_err <= 1'b1;
                  r_err_cause <= CAUSE_TIMEOUT;
               end
            end

            S_DATA: begin
               if (imem_rvalid) begin
                  r_rready <= 1'b0;
                  if (imem_rresp == 2'b00) begin
                     r_state      <= S_HOLD;
                     r_inst       <= imem_rdata;
                     r_fetch_cnt  <= r_fetch_cnt + 32'd1;
                     r_inst_valid <= 1'b1;
                  end else begin
                     r_state     <= S_ERR;
                     r_fetch_err <= 1'b1;
                     r_err_cause <= CAUSE_BUS;
                  end
               end else if (w_timeout) begin
                  r_state     <= S_ERR;
                  r_rready    <= 1'b0;
                  r_fetch_err <= 1'b1;
                  r_err_cause <= CAUSE_TIMEOUT;
               end
            end

            // A dnpc arriving with inst_ready skips WAIT. This gives a
            // single-cycle core back-to-back fetches.
            S_HOLD: begin
               if (inst_ready) begin
                  r_inst_valid <= 1'b0;
                  if (dnpc_valid) begin
                     r_pc <= dnpc;
                     if (w_dnpc_aligned) begin
                        r_state   <= S_ADDR;
                        r_arvalid <= 1'b1;
                     end else begin
                        r_state     <= S_ERR;
                        r_fetch_err <= 1'b1;
                        r_err_cause <= CAUSE_MISALIGN;
                     end
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (dnpc_valid) begin
                  r_pc <= dnpc;
                  if (w_dnpc_aligned) begin
                     r_state   <= S_ADDR;
                     r_arvalid <= 1'b1;
                  end else begin
                     r_state     <= S_ERR;
                     r_fetch_err <= 1'b1;
                     r_err_cause <= CAUSE_MISALIGN;
                  end
               end
            end

            S_ERR: begin
               r_state <= S_ERR;
            end

            default: begin
               r_state      <= S_ERR;
               r_arvalid    <= 1'b0;
               r_rready     <= 1'b0;
               r_inst_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_arvalid = r_arvalid;
   assign imem_araddr  = r_pc;
   assign imem_rready  = r_rready;
   assign inst_valid   = r_inst_valid;
   assign inst         = r_inst;
   assign pc           = r_pc;
   assign fetch_err    = r_fetch_err;
   assign err_cause    = r_err_cause;
   assign fetch_cnt    = r_fetch_cnt;

endmodule
